// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, WB result-select encoding
// and the load funct3 codes decoded during writeback.
package core_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } resultsrc_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bus: the MEM-stage fields entering the stage and the register-file
// write triple (plus WB valid) leaving it.
interface wb_stage_if #(parameter int XLEN = 32);
    logic            mem_valid_i;
    logic            mem_regwrite_i;
    logic [4:0]      mem_rd_i;
    logic [1:0]      mem_resultsrc_i;
    logic [2:0]      mem_funct3_i;
    logic [XLEN-1:0] mem_alu_result_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic [XLEN-1:0] mem_pcplus4_i;
    logic            rf_we_o;
    logic [4:0]      rf_a3_o;
    logic [XLEN-1:0] rf_wd_o;
    logic            wb_valid_o;

    modport master (
        output mem_valid_i, mem_regwrite_i, mem_rd_i, mem_resultsrc_i,
               mem_funct3_i, mem_alu_result_i, mem_rdata_i, mem_pcplus4_i,
        input  rf_we_o, rf_a3_o, rf_wd_o, wb_valid_o
    );

    modport slave (
        input  mem_valid_i, mem_regwrite_i, mem_rd_i, mem_resultsrc_i,
               mem_funct3_i, mem_alu_result_i, mem_rdata_i, mem_pcplus4_i,
        output rf_we_o, rf_a3_o, rf_wd_o, wb_valid_o
    );
endinterface

// File: rtl/load_extend.sv
// Selects the byte/half addressed by the load offset from the aligned memory
// word and sign- or zero-extends it according to funct3.
module load_extend
    import core_pkg::*;
#(
    parameter int LW_XLEN = 32
) (
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         off_i,
    input  logic [LW_XLEN-1:0] rdata_i,
    output logic [LW_XLEN-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        // Halfword offset bit 0 is deliberately ignored (misaligned halves not supported).
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (funct3_i)
            F3_LB:   data_o = {{(LW_XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(LW_XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(LW_XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(LW_XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback: result select, load extension,
// register-file write triple and the retired-instruction counter.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    wb_stage_if.slave        bus,
    output logic [CNT_W-1:0] instret_o
);
    import core_pkg::*;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [4:0]      rd;
        resultsrc_e      src;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] pc4;
    } wb_t;

    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  ld_data;
    logic [XLEN-1:0]  result;

    always_comb begin
        wb_d = wb_q;
        if (flush_i) begin
            wb_d = '0;
        end else if (!stall_i) begin
            wb_d.valid    = bus.mem_valid_i;
            wb_d.regwrite = bus.mem_regwrite_i;
            wb_d.rd       = bus.mem_rd_i;
            wb_d.src      = resultsrc_e'(bus.mem_resultsrc_i);
            wb_d.funct3   = bus.mem_funct3_i;
            wb_d.alu      = bus.mem_alu_result_i;
            wb_d.rdata    = bus.mem_rdata_i;
            wb_d.pc4      = bus.mem_pcplus4_i;
        end
        // Counts the instruction leaving WB; a flush does not cancel that.
        instret_d = instret_q + CNT_W'(wb_q.valid & ~stall_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    load_extend #(.LW_XLEN(XLEN)) u_load_extend (
        .funct3_i (wb_q.funct3),
        .off_i    (wb_q.alu[1:0]),
        .rdata_i  (wb_q.rdata),
        .data_o   (ld_data)
    );

    always_comb begin
        unique case (wb_q.src)
            RES_ALU:  result = wb_q.alu;
            RES_LOAD: result = ld_data;
            RES_PC4:  result = wb_q.pc4;
            default:  result = '0;
        endcase
    end

    assign bus.rf_we_o    = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0);
    assign bus.rf_a3_o    = wb_q.rd;
    assign bus.rf_wd_o    = result;
    assign bus.wb_valid_o = wb_q.valid;
    assign instret_o      = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a transaction-level model of the WB slot and retire count.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, flush;
    logic [63:0] instret;
    logic [3:0]  instret_w;

    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32)) bus ();
    wb_stage_if #(.XLEN(32)) bus_w ();

    assign bus_w.mem_valid_i      = bus.mem_valid_i;
    assign bus_w.mem_regwrite_i   = bus.mem_regwrite_i;
    assign bus_w.mem_rd_i         = bus.mem_rd_i;
    assign bus_w.mem_resultsrc_i  = bus.mem_resultsrc_i;
    assign bus_w.mem_funct3_i     = bus.mem_funct3_i;
    assign bus_w.mem_alu_result_i = bus.mem_alu_result_i;
    assign bus_w.mem_rdata_i      = bus.mem_rdata_i;
    assign bus_w.mem_pcplus4_i    = bus.mem_pcplus4_i;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .bus(bus), .instret_o(instret)
    );

    // Narrow counter copy sees the same stream, so its wrap is reachable.
    wb_stage #(.XLEN(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .bus(bus_w), .instret_o(instret_w)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: contents of the WB slot and number of retirements.
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_src;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_rdata, m_pc4;
    logic [63:0] m_instret;

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd();
        case (m_src)
            2'b00:   return m_alu;
            2'b01:   return load_val(m_f3, m_alu[1:0], m_rdata);
            2'b10:   return m_pc4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_we();
        return m_valid && m_rw && (m_rd != 5'd0);
    endfunction

    task automatic model_clear();
        {m_valid, m_rw, m_rd, m_src, m_f3, m_alu, m_rdata, m_pc4} = '0;
        m_instret = 64'd0;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] src, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic st, input logic fl);
        bus.mem_valid_i      = v;
        bus.mem_regwrite_i   = rw;
        bus.mem_rd_i         = rd;
        bus.mem_resultsrc_i  = src;
        bus.mem_funct3_i     = f3;
        bus.mem_alu_result_i = alu;
        bus.mem_rdata_i      = rdata;
        bus.mem_pcplus4_i    = pc4;
        stall = st;
        flush = fl;
    endtask

    task automatic drive_bubble();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, and
    // return on the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (m_valid && !stall) m_instret = m_instret + 64'd1;
            if (flush) begin
                {m_valid, m_rw, m_rd, m_src, m_f3, m_alu, m_rdata, m_pc4} = '0;
            end else if (!stall) begin
                m_valid = bus.mem_valid_i;   m_rw    = bus.mem_regwrite_i;
                m_rd    = bus.mem_rd_i;      m_src   = bus.mem_resultsrc_i;
                m_f3    = bus.mem_funct3_i;  m_alu   = bus.mem_alu_result_i;
                m_rdata = bus.mem_rdata_i;   m_pc4   = bus.mem_pcplus4_i;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        drive(1'b1, 1'b1, 5'd7, 2'b10, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.rf_we_o); end
        n_cmp++; if (bus.rf_a3_o !== 5'd0) begin n_fail++; $display("FAIL reset_a3 got %0d want 0", bus.rf_a3_o); end
        n_cmp++; if (bus.rf_wd_o !== 32'd0) begin n_fail++; $display("FAIL reset_wd got %h want 0", bus.rf_wd_o); end
        n_cmp++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.wb_valid_o); end
        n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", instret); end
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus.rf_we_o !== 1'b1) begin n_fail++; $display("FAIL first_we got %b want 1", bus.rf_we_o); end
        n_cmp++; if (bus.rf_a3_o !== 5'd5) begin n_fail++; $display("FAIL first_a3 got %0d want 5", bus.rf_a3_o); end
        n_cmp++; if (bus.rf_wd_o !== 32'h1234_5678) begin n_fail++; $display("FAIL first_wd got %h want 12345678", bus.rf_wd_o); end
        n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL first_instret0 got %0d want 0", instret); end
        drive_bubble();
        tick();
        n_cmp++; if (instret !== 64'd1) begin n_fail++; $display("FAIL first_instret1 got %0d want 1", instret); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 5'd3, 2'b01, f3[i], 32'h0000_1000 | 32'(off[i]),
                  32'h80FF_7F01, 32'd0, 1'b0, 1'b0);
            tick();
            n_cmp++;
            if (bus.rf_wd_o !== exp[i]) begin
                n_fail++; $display("FAIL load_f3_%b_off%0d got %h want %h", f3[i], off[i], bus.rf_wd_o, exp[i]);
            end
        end
    endtask

    task automatic test_rd0();
        logic [63:0] want;
        drive(1'b1, 1'b1, 5'd0, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        want = m_instret + 64'd1;
        n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %b want 0", bus.rf_we_o); end
        n_cmp++; if (bus.wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL rd0_valid got %b want 1", bus.wb_valid_o); end
        n_cmp++; if (bus.rf_wd_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd0_wd got %h want deadbeef", bus.rf_wd_o); end
        drive_bubble();
        tick();
        n_cmp++; if (instret !== want) begin n_fail++; $display("FAIL rd0_instret got %0d want %0d", instret, want); end
    endtask

    task automatic test_jal_stall();
        logic [63:0] base;
        drive_bubble();
        tick();
        base = m_instret;
        drive(1'b1, 1'b1, 5'd1, 2'b10, 3'd0, $urandom, $urandom, 32'h0000_0104, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (bus.rf_we_o !== 1'b1 || bus.rf_a3_o !== 5'd1 || bus.rf_wd_o !== 32'h104
                || bus.wb_valid_o !== 1'b1 || instret !== base) begin
                n_fail++;
                $display("FAIL jal_hold_%0d got we=%b a3=%0d wd=%h v=%b cnt=%0d want we=1 a3=1 wd=104 v=1 cnt=%0d",
                         k, bus.rf_we_o, bus.rf_a3_o, bus.rf_wd_o, bus.wb_valid_o, instret, base);
            end
            drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom, 1'b1, 1'b0);
        end
        drive_bubble();
        tick();
        n_cmp++; if (instret !== base + 64'd1) begin n_fail++; $display("FAIL jal_count got %0d want %0d", instret, base + 64'd1); end
    endtask

    task automatic test_flush();
        logic [63:0] base;
        drive_bubble();
        tick();
        drive(1'b1, 1'b1, 5'd9, 2'b00, 3'd0, 32'hA5A5_0001, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        base = m_instret;
        drive(1'b1, 1'b1, 5'd10, 2'b00, 3'd0, 32'h5A5A_0002, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (bus.wb_valid_o !== 1'b0 || bus.rf_we_o !== 1'b0 || bus.rf_a3_o !== 5'd0 || bus.rf_wd_o !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_stall got v=%b we=%b a3=%0d wd=%h want all 0",
                     bus.wb_valid_o, bus.rf_we_o, bus.rf_a3_o, bus.rf_wd_o);
        end
        n_cmp++; if (instret !== base) begin n_fail++; $display("FAIL flush_stall_cnt got %0d want %0d", instret, base); end
        drive(1'b1, 1'b1, 5'd11, 2'b00, 3'd0, 32'h0000_0033, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (instret !== base) begin n_fail++; $display("FAIL bubble_cnt got %0d want %0d", instret, base); end
        drive(1'b1, 1'b1, 5'd12, 2'b00, 3'd0, 32'h0000_0044, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (instret !== base + 64'd1) begin n_fail++; $display("FAIL flush_counts_leaving got %0d want %0d", instret, base + 64'd1); end
        n_cmp++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.wb_valid_o); end
    endtask

    task automatic test_wrap();
        logic saw_wrap = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 5'd2, 2'b00, 3'd0, 32'(k), 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
            if (m_instret[3:0] == 4'd0) saw_wrap = 1'b1;
            n_cmp++;
            if (instret_w !== m_instret[3:0] || instret !== m_instret) begin
                n_fail++; $display("FAIL wrap_%0d got w4=%0d w64=%0d want w4=%0d w64=%0d",
                                   k, instret_w, instret, m_instret[3:0], m_instret);
            end
        end
        n_cmp++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_reached got %b want 1", saw_wrap); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'd0, 32'h0000_00AA, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (bus.rf_we_o !== 1'b0 || bus.rf_a3_o !== 5'd0 || bus.rf_wd_o !== 32'd0
            || bus.wb_valid_o !== 1'b0 || instret !== 64'd0 || instret_w !== 4'd0) begin
            n_fail++;
            $display("FAIL async_clear got we=%b a3=%0d wd=%h v=%b cnt=%0d cnt4=%0d want all 0",
                     bus.rf_we_o, bus.rf_a3_o, bus.rf_wd_o, bus.wb_valid_o, instret, instret_w);
        end
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'd0, 32'h0000_00AA, 32'd0, 32'd0, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'd0, 32'h0000_00AA, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_release_valid got %b want 0", bus.wb_valid_o); end
        tick();
        n_cmp++;
        if (bus.rf_we_o !== 1'b1 || bus.rf_a3_o !== 5'd4 || bus.rf_wd_o !== 32'hAA || instret !== 64'd0) begin
            n_fail++;
            $display("FAIL first_capture got we=%b a3=%0d wd=%h cnt=%0d want we=1 a3=4 wd=aa cnt=0",
                     bus.rf_we_o, bus.rf_a3_o, bus.rf_wd_o, instret);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                  $urandom, $urandom, $urandom, ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0));
            tick();
            n_cmp++;
            if (bus.rf_we_o !== exp_we() || bus.rf_a3_o !== m_rd || bus.rf_wd_o !== exp_wd()
                || bus.wb_valid_o !== m_valid || instret !== m_instret || instret_w !== m_instret[3:0]) begin
                n_fail++;
                $display("FAIL rand_%0d got we=%b a3=%0d wd=%h v=%b cnt=%0d want we=%b a3=%0d wd=%h v=%b cnt=%0d",
                         k, bus.rf_we_o, bus.rf_a3_o, bus.rf_wd_o, bus.wb_valid_o, instret,
                         exp_we(), m_rd, exp_wd(), m_valid, m_instret);
            end
        end
    endtask

    initial begin
        model_clear();
        drive_bubble();
        test_reset();
        test_loads();
        test_rd0();
        test_jal_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
